// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared state encoding and round-group constants for the SHA-1 sequencer
package sha1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_WAIT_BLK = 3'd2,
    ST_ROUND    = 3'd3,
    ST_ADD      = 3'd4,
    ST_FINISH   = 3'd5
  } sha1_state_e;

  localparam int SHA1_ROUNDS = 80;
  localparam int SHA1_GRP1   = 20;
  localparam int SHA1_GRP2   = 40;
  localparam int SHA1_GRP3   = 60;

  // Saturates at 3 so a longer ROUNDS override cannot select a fifth K.
  function automatic logic [1:0] sha1_fsel(input logic [6:0] idx);
    if (idx >= 7'(SHA1_GRP3)) return 2'd3;
    if (idx >= 7'(SHA1_GRP2)) return 2'd2;
    if (idx >= 7'(SHA1_GRP1)) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/sha1_round_counter.sv
// rtl/sha1_round_counter.sv - round index counter with RPC step, terminal flag and fsel decode
module sha1_round_counter
  import sha1_pkg::*;
#(
  parameter int ROUNDS = SHA1_ROUNDS,
  parameter int RPC    = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       clr_i,
  input  logic       step_i,
  output logic [6:0] round_idx_o,
  output logic       last_o,
  output logic [1:0] fsel_o
);

  localparam logic [6:0] STEP     = 7'(RPC);
  localparam logic [6:0] LAST_IDX = 7'(ROUNDS - RPC);

  logic [6:0] idx_q, idx_d;

  assign last_o      = (idx_q == LAST_IDX);
  assign round_idx_o = idx_q;
  assign fsel_o      = sha1_fsel(idx_q);

  // Wraps to 0 on the terminal step so the index is already 0 in ADD.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (step_i) begin
      idx_d = last_o ? 7'd0 : idx_q + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/sha1_round_sequencer.sv
// rtl/sha1_round_sequencer.sv - control FSM sequencing IV load, block intake, rounds and digest add
module sha1_round_sequencer
  import sha1_pkg::*;
#(
  parameter int ROUNDS = SHA1_ROUNDS,
  parameter int RPC    = 1,
  parameter int BLK_W  = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [BLK_W-1:0] num_blocks,
  input  logic             blk_valid,
  input  logic             abort,
  output logic             blk_ready,
  output logic             load_iv,
  output logic             load_block,
  output logic             round_en,
  output logic [6:0]       round_idx,
  output logic [1:0]       fsel,
  output logic             add_digest,
  output logic [2:0]       state,
  output logic [BLK_W-1:0] blocks_left,
  output logic             busy,
  output logic             done,
  output logic             err
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 5)) begin : g_bad_rpc
    $error("sha1_round_sequencer: RPC must be 1, 2, 4 or 5");
  end

  sha1_state_e      state_q, state_d;
  logic [BLK_W-1:0] nblk_q, nblk_d;
  logic [BLK_W-1:0] left_q, left_d;
  logic             err_q, err_d;
  logic             round_last;

  sha1_round_counter #(
    .ROUNDS (ROUNDS),
    .RPC    (RPC)
  ) u_cnt (
    .clk         (clk),
    .nreset      (nreset),
    .clr_i       (abort || (state_q != ST_ROUND)),
    .step_i      (state_q == ST_ROUND),
    .round_idx_o (round_idx),
    .last_o      (round_last),
    .fsel_o      (fsel)
  );

  always_comb begin
    state_d = state_q;
    nblk_d  = nblk_q;
    left_d  = left_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_blocks != '0) begin
            state_d = ST_INIT;
            nblk_d  = num_blocks;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_INIT: begin
        left_d  = nblk_q;
        state_d = ST_WAIT_BLK;
      end
      ST_WAIT_BLK: if (blk_valid) state_d = ST_ROUND;
      ST_ROUND:    if (round_last) state_d = ST_ADD;
      ST_ADD: begin
        left_d  = left_q - BLK_W'(1);
        state_d = (left_q == BLK_W'(1)) ? ST_FINISH : ST_WAIT_BLK;
      end
      ST_FINISH:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // Abort overrides every transition above, including the final ADD.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      left_d  = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      nblk_q  <= '0;
      left_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nblk_q  <= nblk_d;
      left_q  <= left_d;
      err_q   <= err_d;
    end
  end

  assign blk_ready   = (state_q == ST_WAIT_BLK);
  assign load_iv     = (state_q == ST_INIT);
  assign load_block  = (state_q == ST_WAIT_BLK) && blk_valid;
  assign round_en    = (state_q == ST_ROUND);
  assign add_digest  = (state_q == ST_ADD);
  assign done        = (state_q == ST_FINISH);
  assign busy        = (state_q != ST_IDLE);
  assign state       = state_q;
  assign blocks_left = left_q;
  assign err         = err_q;

endmodule
